// File: rtl/common.sv
// Shared cbus request/response types and the arbiter FSM state encoding.
package common;

  typedef enum logic [1:0] {
    MLEN1 = 2'd0,
    MLEN2 = 2'd1,
    MLEN4 = 2'd2,
    MLEN8 = 2'd3
  } cbus_len_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
    cbus_len_t   len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic        err;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cbus_arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first valid port searching upward from last+1, wrapping.
module arb_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IDX_W-1:0]     last,
  output logic                 found,
  output logic [IDX_W-1:0]     winner
);

  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= NUM_PORTS) ? (sum - NUM_PORTS) : sum;
  endfunction

  // Scan farthest-first so the nearest valid port after last overwrites the result.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      found  = valid[IDX_W'(wrap_idx(int'(last), k))] ? 1'b1 : found;
      winner = valid[IDX_W'(wrap_idx(int'(last), k))] ? IDX_W'(wrap_idx(int'(last), k)) : winner;
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N:1 cbus arbiter holding a grant for a whole burst; round-robin by default,
// fixed lowest-index priority when CBUS_ARB_FIXED_PRIO_EN is defined.
module cbus_rr_arbiter
  import common::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_PORTS],
  output cbus_resp_t       iresps [NUM_PORTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  cbus_arb_state_t        state_r;
  logic [IDX_W-1:0]       sel_r;
  logic                   busy_r;
  logic [IDX_W-1:0]       grant_idx_r;
  logic [NUM_PORTS-1:0]   valid_s;
  logic                   found_s;
  logic [IDX_W-1:0]       winner_s;
  logic [IDX_W-1:0]       pick_last_s;
  logic                   done_s;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_valid
    assign valid_s[i] = ireqs[i].valid;
  end

  // A burst ends on the final beat or when the owner aborts by dropping valid.
  assign done_s = !ireqs[sel_r].valid || (oresp.ready && oresp.last);

`ifdef CBUS_ARB_FIXED_PRIO_EN
  // Searching from NUM_PORTS-1 upward always starts at port 0.
  assign pick_last_s = IDX_W'(NUM_PORTS - 1);
`else
  logic [IDX_W-1:0] last_r;

  assign pick_last_s = last_r;

  // Remember the port that just released the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= IDX_W'(NUM_PORTS - 1);
    end else if (state_r == BUSY && done_s) begin
      last_r <= sel_r;
    end
  end
`endif

  arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .valid  (valid_s),
    .last   (pick_last_s),
    .found  (found_s),
    .winner (winner_s)
  );

  // Grant FSM with registered busy/grant_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      busy_r      <= 1'b0;
      grant_idx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r     <= BUSY;
            sel_r       <= winner_s;
            busy_r      <= 1'b1;
            grant_idx_r <= winner_s;
          end
        end
        BUSY: begin
          if (done_s) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            grant_idx_r <= '0;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          grant_idx_r <= '0;
        end
      endcase
    end
  end

  // Route the owner's request down and the response back only to the owner.
  always_comb begin
    oreq   = '0;
    iresps = '{default: '0};
    if (state_r == BUSY) begin
      oreq          = ireqs[sel_r];
      iresps[sel_r] = oresp;
    end else begin
      oreq = '0;
    end
  end

  assign busy      = busy_r;
  assign grant_idx = grant_idx_r;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter (4 ports); expectations follow CBUS_ARB_FIXED_PRIO_EN.
module tb_cbus_rr_arbiter;
  import common::*;

  localparam int NP = 4;
  localparam int IW = 2;
`ifdef CBUS_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic          clk;
  logic          reset;
  cbus_req_t     ireqs  [NP];
  cbus_resp_t    iresps [NP];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic          busy;
  logic [IW-1:0] grant_idx;

  int num_checks;
  int num_errors;

  cbus_rr_arbiter #(
    .NUM_PORTS (NP),
    .IDX_W     (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NP; i++) ireqs[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    oresp = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Grant one single-beat burst to exp_idx, starting from a settled IDLE cycle.
  task automatic serve(input int exp_idx);
    tick();
    oresp       = '0;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.rdata = 32'h5A00 + 32'(exp_idx);
    settle();
    check_val("serve_busy", 32'(busy), 32'd1);
    check_val("serve_grant", 32'(grant_idx), 32'(exp_idx));
    check_val("serve_resp_last", 32'(iresps[exp_idx].last), 32'd1);
    tick();
    oresp = '0;
    settle();
    check_val("serve_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_own;
    num_checks = 0;
    num_errors = 0;
    reset = 1'b1;
    clear_reqs();
    oresp = '0;

    // Reset state
    tick();
    settle();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_grant", 32'(grant_idx), 32'd0);
    check_val("rst_oreq", 32'(oreq.valid), 32'd0);
    check_val("rst_iresp0", 32'(iresps[0].ready), 32'd0);
    reset = 1'b0;

    // Response while IDLE is discarded
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.rdata = 32'hBEEF;
    settle();
    check_val("idle_resp0", 32'(iresps[0].ready), 32'd0);
    check_val("idle_resp1", iresps[1].rdata, 32'd0);
    oresp = '0;

    // Port 1 MLEN4 burst; port 0 raises valid on the last beat
    ireqs[1].valid = 1'b1;
    ireqs[1].len   = MLEN4;
    ireqs[1].addr  = 32'h100;
    ireqs[1].burst = BURST_INCR;
    ireqs[1].strb  = 4'hF;
    settle();
    check_val("lat_busy", 32'(busy), 32'd0);
    check_val("lat_oreq", 32'(oreq.valid), 32'd0);
    tick();
    settle();
    check_val("b4_busy", 32'(busy), 32'd1);
    check_val("b4_grant", 32'(grant_idx), 32'd1);
    check_val("b4_oreq_valid", 32'(oreq.valid), 32'd1);
    check_val("b4_oreq_addr", oreq.addr, 32'h100);
    check_val("b4_oreq_len", 32'(oreq.len), 32'(MLEN4));
    check_val("b4_oreq_strb", 32'(oreq.strb), 32'hF);
    for (int b = 0; b < 4; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == 3);
      oresp.rdata = 32'hA0 + 32'(b);
      if (b == 3) ireqs[0].valid = 1'b1;
      settle();
      check_val("b4_rdata", iresps[1].rdata, 32'hA0 + 32'(b));
      check_val("b4_other_zero", 32'(iresps[0].ready), 32'd0);
      check_val("b4_hold_grant", 32'(grant_idx), 32'd1);
      tick();
    end
    oresp = '0;
    ireqs[1].valid = 1'b0;
    settle();
    check_val("b4_end_idle", 32'(busy), 32'd0);
    check_val("b4_end_oreq", 32'(oreq.valid), 32'd0);
    serve(0);
    clear_reqs();

    // Two ports valid continuously, single-beat bursts
    do_reset();
    ireqs[0].valid = 1'b1;
    ireqs[0].len   = MLEN1;
    ireqs[1].valid = 1'b1;
    ireqs[1].len   = MLEN1;
    settle();
    for (int n = 0; n < 4; n++) serve(FIXED_PRIO ? 0 : (n % 2));
    clear_reqs();

    // last=3 after reset, ports 1 and 2 valid
    do_reset();
    ireqs[1].valid = 1'b1;
    ireqs[2].valid = 1'b1;
    settle();
    serve(1);
    serve(FIXED_PRIO ? 1 : 2);
    clear_reqs();

    // Port 0 aborts an MLEN8 burst after 2 beats
    do_reset();
    ireqs[0].valid = 1'b1;
    ireqs[0].len   = MLEN8;
    settle();
    tick();
    settle();
    check_val("ab_grant", 32'(grant_idx), 32'd0);
    check_val("ab_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 2; b++) begin
      oresp.ready = 1'b1;
      oresp.rdata = 32'hC0 + 32'(b);
      settle();
      check_val("ab_beat", iresps[0].rdata, 32'hC0 + 32'(b));
      tick();
    end
    ireqs[0].valid = 1'b0;
    oresp = '0;
    settle();
    check_val("ab_oreq_low", 32'(oreq.valid), 32'd0);
    tick();
    oresp.ready = 1'b1;
    oresp.rdata = 32'hDEAD;
    settle();
    check_val("ab_busy_next", 32'(busy), 32'd0);
    check_val("ab_iresp0_rdy", 32'(iresps[0].ready), 32'd0);
    check_val("ab_iresp0_data", iresps[0].rdata, 32'd0);
    oresp = '0;

    // Reset asserted at beat 3 of a burst
    do_reset();
    ireqs[0].valid = 1'b1;
    ireqs[0].len   = MLEN4;
    ireqs[1].valid = 1'b1;
    ireqs[1].len   = MLEN4;
    settle();
    serve(0);
    exp_own = FIXED_PRIO ? 0 : 1;
    tick();
    settle();
    check_val("mr_grant", 32'(grant_idx), 32'(exp_own));
    for (int b = 0; b < 3; b++) begin
      oresp.ready = 1'b1;
      oresp.rdata = 32'hE0 + 32'(b);
      settle();
      check_val("mr_beat", 32'(iresps[exp_own].ready), 32'd1);
      tick();
    end
    oresp.ready = 1'b1;
    settle();
    reset = 1'b1;
    #1;
    check_val("mr_oreq_zero", 32'(oreq.valid), 32'd0);
    check_val("mr_busy", 32'(busy), 32'd0);
    check_val("mr_grant0", 32'(grant_idx), 32'd0);
    check_val("mr_iresp_zero", 32'(iresps[exp_own].ready), 32'd0);
    tick();
    reset = 1'b0;
    oresp = '0;
    settle();
    check_val("mr_rel_idle", 32'(busy), 32'd0);
    tick();
    settle();
    check_val("mr_first_busy", 32'(busy), 32'd1);
    check_val("mr_first_grant", 32'(grant_idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
